// File: rtl/chaos_key_stream_if.sv
// Control and key-stream handshake bundle between the chaotic key generator and its host.
interface chaos_key_stream_if #(
    parameter int unsigned W = 32
);
    logic         ENABLE;
    logic         SEED_LOAD;
    logic [W-1:0] SEED;
    logic         KEY_VALID;
    logic         KEY_READY;
    logic [31:0]  KEY_DATA;
    logic         BUSY;
    logic [31:0]  WORD_CNT;

    modport master (
        output ENABLE, SEED_LOAD, SEED, KEY_READY,
        input  KEY_VALID, KEY_DATA, BUSY, WORD_CNT
    );

    modport slave (
        input  ENABLE, SEED_LOAD, SEED, KEY_READY,
        output KEY_VALID, KEY_DATA, BUSY, WORD_CNT
    );
endinterface

// File: rtl/chaos_key_stream.sv
// Fixed-point 4D hyperchaotic key generator: one shared multiplier sequenced over 12 products
// per Euler step, ITER steps per key word, words buffered in a show-ahead FIFO.
module chaos_key_stream #(
    parameter int unsigned  W          = 32,
    parameter int unsigned  FRAC       = 24,
    parameter int unsigned  ITER       = 4,
    parameter int unsigned  KSH        = 10,
    parameter int unsigned  FIFO_DEPTH = 4,
    parameter logic [W-1:0] A          = W'(32'h14000000),
    parameter logic [W-1:0] B          = W'(32'h00800000),
    parameter logic [W-1:0] C          = W'(32'h06CCCCCC),
    parameter logic [W-1:0] D          = W'(32'h08000000),
    parameter logic [W-1:0] E          = W'(32'h00800000),
    parameter logic [W-1:0] T          = W'(32'h00028F5C),
    parameter logic [W-1:0] INIT       = W'(32'h00199999)
) (
    input logic               CLK,
    input logic               RESET,
    chaos_key_stream_if.slave key_if
);
    localparam int unsigned NMUL = 12;
    localparam int unsigned IW   = 4;
    localparam int unsigned SW   = 8;
    localparam int unsigned SW1  = SW + 1;
    localparam int unsigned AW   = $clog2(FIFO_DEPTH);
    localparam int unsigned CW   = AW + 1;
    localparam int unsigned LSB  = FRAC - KSH;
    localparam int unsigned PW   = 2 * W;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_UPD, S_PUSH} state_e;

    state_e state_q, state_d;
    logic   calc_en, upd_en, push_en, step_clr;

    logic [IW-1:0] idx_q, idx_d;
    logic [SW-1:0] step_q, step_d;
    logic          last_idx, last_step;
    logic [W-1:0]  x_q, y_q, z_q, w_q, x_d, y_d, z_d, w_d;
    logic [W-1:0]  prod_q [NMUL];
    logic [W-1:0]  dx, dy, dz, dw, mul_a, mul_b, mul_r;
    logic signed [PW-1:0] mul_ax, mul_bx;

    logic [31:0]   fifo_q [FIFO_DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pop, full, full_after;
    logic [31:0]   lane_word, wcnt_q, wcnt_d;
    logic          valid_q, valid_d, busy_q, busy_d;

    assign last_idx   = (idx_q == IW'(NMUL - 1));
    assign last_step  = ((SW1'(step_q) + SW1'(1)) == SW1'(ITER));
    assign pop        = valid_q & key_if.KEY_READY;
    assign full       = (cnt_q == CW'(FIFO_DEPTH));
    assign full_after = (cnt_d == CW'(FIFO_DEPTH));

    // Derivatives are summed from the registered products of the current step.
    assign dx = prod_q[0] + prod_q[1] + w_q;
    assign dy = prod_q[2] + prod_q[3] - prod_q[4] - prod_q[5];
    assign dz = prod_q[6] - prod_q[7];
    assign dw = x_q - w_q;

    always_comb begin : operand_mux
        mul_a = T;
        mul_b = dw;
        case (idx_q)
            IW'(0):  begin mul_a = A;   mul_b = y_q - x_q; end
            IW'(1):  begin mul_a = y_q; mul_b = z_q;       end
            IW'(2):  begin mul_a = B;   mul_b = x_q;       end
            IW'(3):  begin mul_a = C;   mul_b = y_q;       end
            IW'(4):  begin mul_a = x_q; mul_b = z_q;       end
            IW'(5):  begin mul_a = E;   mul_b = w_q;       end
            IW'(6):  begin mul_a = x_q; mul_b = x_q;       end
            IW'(7):  begin mul_a = D;   mul_b = z_q;       end
            IW'(8):  mul_b = dx;
            IW'(9):  mul_b = dy;
            IW'(10): mul_b = dz;
            default: ;
        endcase
    end

    // Full-width signed product, floor-shifted back to Q(W-FRAC).FRAC and wrapped to W bits.
    assign mul_ax = {{W{mul_a[W-1]}}, mul_a};
    assign mul_bx = {{W{mul_b[W-1]}}, mul_b};
    assign mul_r  = W'((mul_ax * mul_bx) >>> FRAC);

    assign lane_word = {w_q[LSB +: 8], z_q[LSB +: 8], y_q[LSB +: 8], x_q[LSB +: 8]};

    always_ff @(posedge CLK) begin : state_reg
        if (RESET) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin : next_state
        state_d = state_q;
        if (key_if.SEED_LOAD) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (key_if.ENABLE && !full) state_d = S_CALC;
                S_CALC:  if (last_idx) state_d = S_UPD;
                S_UPD:   state_d = last_step ? S_PUSH : S_CALC;
                S_PUSH:  state_d = (key_if.ENABLE && !full_after) ? S_CALC : S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
        busy_d = (state_d != S_IDLE);
    end

    always_comb begin : state_outputs
        calc_en  = 1'b0;
        upd_en   = 1'b0;
        push_en  = 1'b0;
        step_clr = 1'b0;
        case (state_q)
            S_IDLE:  step_clr = 1'b1;
            S_CALC:  calc_en  = 1'b1;
            S_UPD:   upd_en   = 1'b1;
            S_PUSH:  begin push_en = 1'b1; step_clr = 1'b1; end
            default: ;
        endcase
    end

    // SEED_LOAD overrides every datapath and FIFO update of the cycle.
    always_comb begin : datapath_next
        x_d    = x_q;
        y_d    = y_q;
        z_d    = z_q;
        w_d    = w_q;
        idx_d  = (calc_en && !last_idx) ? idx_q + IW'(1) : '0;
        step_d = step_q;
        wr_d   = wr_q;
        rd_d   = rd_q;
        cnt_d  = cnt_q;
        wcnt_d = wcnt_q;
        if (step_clr)    step_d = '0;
        else if (upd_en) step_d = step_q + SW'(1);
        if (upd_en) begin
            x_d = x_q + prod_q[8];
            y_d = y_q + prod_q[9];
            z_d = z_q + prod_q[10];
            w_d = w_q + prod_q[11];
        end
        if (push_en) begin
            wr_d   = wr_q + AW'(1);
            wcnt_d = wcnt_q + 32'd1;
        end
        if (pop) rd_d = rd_q + AW'(1);
        case ({push_en, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: ;
        endcase
        if (key_if.SEED_LOAD) begin
            x_d    = key_if.SEED;
            y_d    = INIT;
            z_d    = INIT;
            w_d    = INIT;
            idx_d  = '0;
            step_d = '0;
            wr_d   = '0;
            rd_d   = '0;
            cnt_d  = '0;
            wcnt_d = '0;
        end
        valid_d = (cnt_d != '0);
    end

    always_ff @(posedge CLK) begin : datapath_reg
        if (RESET) begin
            x_q     <= INIT;
            y_q     <= INIT;
            z_q     <= INIT;
            w_q     <= INIT;
            idx_q   <= '0;
            step_q  <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            wcnt_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            for (int i = 0; i < int'(NMUL); i++) prod_q[i] <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) fifo_q[i] <= '0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            w_q     <= w_d;
            idx_q   <= idx_d;
            step_q  <= step_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            wcnt_q  <= wcnt_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            if (calc_en && !key_if.SEED_LOAD) prod_q[idx_q] <= mul_r;
            if (push_en && !key_if.SEED_LOAD) fifo_q[wr_q] <= lane_word;
        end
    end

    assign key_if.KEY_VALID = valid_q;
    assign key_if.KEY_DATA  = fifo_q[rd_q];
    assign key_if.BUSY      = busy_q;
    assign key_if.WORD_CNT  = wcnt_q;
endmodule

// File: tb/tb_chaos_key_stream.sv
// Bench for chaos_key_stream: three parameterisations, fixed-point reference model feeding
// an expected-word queue that is drained on every accepted key beat.
module tb_chaos_key_stream;
    localparam logic [31:0] CA    = 32'h14000000;
    localparam logic [31:0] CB    = 32'h00800000;
    localparam logic [31:0] CC    = 32'h06CCCCCC;
    localparam logic [31:0] CD    = 32'h08000000;
    localparam logic [31:0] CE    = 32'h00800000;
    localparam logic [31:0] CT    = 32'h00028F5C;
    localparam logic [31:0] CINIT = 32'h00199999;
    localparam int          MITER = 4;
    localparam int          NW    = 300;

    logic CLK = 1'b0;
    logic RESET;
    int   checks   = 0;
    int   failures = 0;

    logic [31:0] exp_q [$];
    logic [31:0] mx, my, mz, mw;

    always #5 CLK = ~CLK;

    chaos_key_stream_if #(.W(32)) if0 ();
    chaos_key_stream_if #(.W(32)) if1 ();
    chaos_key_stream_if #(.W(32)) if2 ();

    chaos_key_stream u_def (
        .CLK    (CLK),
        .RESET  (RESET),
        .key_if (if0)
    );

    chaos_key_stream #(.T(32'h0), .ITER(1)) u_t0 (
        .CLK    (CLK),
        .RESET  (RESET),
        .key_if (if1)
    );

    chaos_key_stream #(.INIT(32'h0), .ITER(1)) u_zero (
        .CLK    (CLK),
        .RESET  (RESET),
        .key_if (if2)
    );

    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] p;
        p = 64'($signed(a)) * 64'($signed(b));
        p = p >>> 24;
        return p[31:0];
    endfunction

    task automatic model_seed(input logic [31:0] s);
        mx = s;
        my = CINIT;
        mz = CINIT;
        mw = CINIT;
    endtask

    task automatic model_word(output logic [31:0] word);
        logic [31:0] dx, dy, dz, dw;
        for (int n = 0; n < MITER; n++) begin
            dx = fmul(CA, my - mx) + fmul(my, mz) + mw;
            dy = fmul(CB, mx) + fmul(CC, my) - fmul(mx, mz) - fmul(CE, mw);
            dz = fmul(mx, mx) - fmul(CD, mz);
            dw = mx - mw;
            mx = mx + fmul(CT, dx);
            my = my + fmul(CT, dy);
            mz = mz + fmul(CT, dz);
            mw = mw + fmul(CT, dw);
        end
        word = {mw[21:14], mz[21:14], my[21:14], mx[21:14]};
    endtask

    task automatic push_expected(input int n);
        logic [31:0] wd;
        for (int i = 0; i < n; i++) begin
            model_word(wd);
            exp_q.push_back(wd);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Drive the default instance for one cycle; a beat accepted at the coming edge is scored now.
    task automatic cyc0(input logic en, input logic rdy);
        if0.ENABLE    = en;
        if0.KEY_READY = rdy;
        if (if0.KEY_VALID === 1'b1 && rdy) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                failures++;
                $error("FAIL sb_underflow observed=%h expected=no further word", if0.KEY_DATA);
            end
            if (exp_q.size() != 0) chk("key_word", if0.KEY_DATA, exp_q.pop_front());
        end
        @(negedge CLK);
    endtask

    task automatic wait_valid1(output int n);
        n = 0;
        for (int i = 1; i <= 40 && n == 0; i++) begin
            @(negedge CLK);
            if (if1.KEY_VALID === 1'b1) n = i;
        end
    endtask

    initial begin
        int lat;

        RESET = 1'b1;
        if0.ENABLE = 1'b0; if0.SEED_LOAD = 1'b0; if0.SEED = '0; if0.KEY_READY = 1'b0;
        if1.ENABLE = 1'b1; if1.SEED_LOAD = 1'b0; if1.SEED = '0; if1.KEY_READY = 1'b1;
        if2.ENABLE = 1'b0; if2.SEED_LOAD = 1'b0; if2.SEED = '0; if2.KEY_READY = 1'b1;
        repeat (3) @(negedge CLK);

        chk("rst_valid", 32'(if0.KEY_VALID), 32'd0);
        chk("rst_data", if0.KEY_DATA, 32'd0);
        chk("rst_busy", 32'(if0.BUSY), 32'd0);
        chk("rst_word_cnt", if0.WORD_CNT, 32'd0);
        chk("rst_busy_t0", 32'(if1.BUSY), 32'd0);
        RESET = 1'b0;

        // T=0, ITER=1: state frozen at INIT, word out 14 cycles after the start edge
        wait_valid1(lat);
        chk("t0_first_valid_cycle", 32'(lat), 32'd15);
        chk("t0_key_data", if1.KEY_DATA, 32'h66666666);
        chk("t0_word_cnt", if1.WORD_CNT, 32'd1);

        if1.SEED_LOAD = 1'b1;
        if1.SEED      = 32'h01000000;
        @(negedge CLK);
        if1.SEED_LOAD = 1'b0;
        chk("t0_seed_valid", 32'(if1.KEY_VALID), 32'd0);
        chk("t0_seed_word_cnt", if1.WORD_CNT, 32'd0);
        wait_valid1(lat);
        chk("t0_seed_first_valid_cycle", 32'(lat), 32'd15);
        chk("t0_seed_key_data", if1.KEY_DATA, 32'h66666600);
        chk("t0_seed_word_cnt_restart", if1.WORD_CNT, 32'd1);
        if1.ENABLE = 1'b0;

        // INIT=0, SEED=0: all-zero words, one every 14 cycles
        if2.SEED_LOAD = 1'b1;
        if2.SEED      = 32'h0;
        if2.ENABLE    = 1'b1;
        @(negedge CLK);
        if2.SEED_LOAD = 1'b0;
        for (int i = 1; i <= 43; i++) begin
            @(negedge CLK);
            if (i == 14) chk("zero_cnt_before_push", if2.WORD_CNT, 32'd0);
            if (i == 15) begin
                chk("zero_cnt_1", if2.WORD_CNT, 32'd1);
                chk("zero_valid", 32'(if2.KEY_VALID), 32'd1);
                chk("zero_data", if2.KEY_DATA, 32'd0);
            end
            if (i == 29) chk("zero_cnt_2", if2.WORD_CNT, 32'd2);
            if (i == 43) chk("zero_cnt_3", if2.WORD_CNT, 32'd3);
        end
        if2.ENABLE = 1'b0;

        // Backpressure: FIFO fills to depth, FSM parks in IDLE with the head word held
        model_seed(CINIT);
        push_expected(4);
        repeat (240) cyc0(1'b1, 1'b0);
        chk("bp_word_cnt", if0.WORD_CNT, 32'd4);
        chk("bp_busy", 32'(if0.BUSY), 32'd0);
        chk("bp_valid", 32'(if0.KEY_VALID), 32'd1);
        chk("bp_head", if0.KEY_DATA, exp_q[0]);
        repeat (20) cyc0(1'b1, 1'b0);
        chk("bp_hold_data", if0.KEY_DATA, exp_q[0]);
        chk("bp_hold_cnt", if0.WORD_CNT, 32'd4);
        cyc0(1'b1, 1'b1);
        chk("bp_idle_at_pop", 32'(if0.BUSY), 32'd0);
        cyc0(1'b1, 1'b0);
        chk("bp_restart_busy", 32'(if0.BUSY), 32'd1);

        // Random ready / enable: every accepted word must match the model in order
        push_expected(NW);
        for (int c = 0; c < 40000 && exp_q.size() != 0; c++)
            cyc0(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1) == 1));
        chk("random_all_words", 32'(exp_q.size()), 32'd0);

        // Seed load flushes; two words buffered then abort mid-step
        if0.SEED_LOAD = 1'b1;
        if0.SEED      = 32'h00333333;
        if0.KEY_READY = 1'b0;
        @(negedge CLK);
        if0.SEED_LOAD = 1'b0;
        chk("seed_flush_valid", 32'(if0.KEY_VALID), 32'd0);
        chk("seed_flush_cnt", if0.WORD_CNT, 32'd0);
        exp_q.delete();
        model_seed(32'h00333333);
        push_expected(2);
        for (int c = 0; c < 400 && if0.WORD_CNT != 32'd2; c++) cyc0(1'b1, 1'b0);
        chk("abort_pre_cnt", if0.WORD_CNT, 32'd2);
        repeat (5) cyc0(1'b1, 1'b0);
        chk("abort_pre_busy", 32'(if0.BUSY), 32'd1);
        chk("abort_pre_head", if0.KEY_DATA, exp_q[0]);

        if0.SEED_LOAD = 1'b1;
        if0.SEED      = 32'hFFE66667;
        if0.ENABLE    = 1'b0;
        @(negedge CLK);
        if0.SEED_LOAD = 1'b0;
        chk("abort_valid", 32'(if0.KEY_VALID), 32'd0);
        chk("abort_busy", 32'(if0.BUSY), 32'd0);
        chk("abort_cnt", if0.WORD_CNT, 32'd0);
        repeat (60) cyc0(1'b0, 1'b1);
        chk("abort_no_push_cnt", if0.WORD_CNT, 32'd0);
        chk("abort_no_push_valid", 32'(if0.KEY_VALID), 32'd0);
        exp_q.delete();
        model_seed(32'hFFE66667);
        push_expected(2);
        for (int c = 0; c < 400 && exp_q.size() != 0; c++) cyc0(1'b1, 1'b1);
        chk("reseed_words", 32'(exp_q.size()), 32'd0);

        // RESET wins over a simultaneous SEED_LOAD
        RESET         = 1'b1;
        if0.SEED_LOAD = 1'b1;
        if0.SEED      = 32'h12345678;
        if0.ENABLE    = 1'b0;
        @(negedge CLK);
        RESET         = 1'b0;
        if0.SEED_LOAD = 1'b0;
        chk("rst_seed_valid", 32'(if0.KEY_VALID), 32'd0);
        chk("rst_seed_cnt", if0.WORD_CNT, 32'd0);
        chk("rst_seed_busy", 32'(if0.BUSY), 32'd0);
        exp_q.delete();
        model_seed(CINIT);
        push_expected(1);
        for (int c = 0; c < 200 && exp_q.size() != 0; c++) cyc0(1'b1, 1'b1);
        chk("rst_seed_word", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
